// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  typedef logic [0:0] port_idx_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester-side bus of the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  import dmem_arb_pkg::*;

  logic [NUM_PORTS-1:0] req_i;
  logic [NUM_PORTS-1:0] we_i;
  logic [NUM_PORTS-1:0] lock_i;
  logic [ADDR_W-1:0]    addr0_i;
  logic [ADDR_W-1:0]    addr1_i;
  logic [DATA_W-1:0]    wdata0_i;
  logic [DATA_W-1:0]    wdata1_i;
  logic [NUM_PORTS-1:0] gnt_o;
  logic [NUM_PORTS-1:0] rvalid_o;
  logic [DATA_W-1:0]    rdata_o;

  modport master (
    output req_i, we_i, lock_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, lock_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    output gnt_o, rvalid_o, rdata_o
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - winner selection; DMEM_ARB_ROUND_ROBIN_EN selects round robin, else fixed priority
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            last_owner,
  output port_idx_t            winner
);

  // With no request the result is never latched; holding last_owner keeps it stable.
  always_comb begin
    winner = last_owner;
    if (req[0] && req[1]) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      winner = ~last_owner;
`else
      winner = 1'b0;
`endif
    end else if (req[0]) begin
      winner = 1'b0;
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port request/grant arbiter for the single-port data memory
// Build option DMEM_ARB_ROUND_ROBIN_EN: round-robin on contention instead of port-0 priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     bus,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_t           state, state_d;
  port_idx_t            owner, owner_d;
  port_idx_t            last_owner;
  port_idx_t            winner;
  logic [DATA_W-1:0]    rdata;
  logic [NUM_PORTS-1:0] rvalid;
  logic [NUM_PORTS-1:0] gnt;
  logic                 access;

  dmem_arb_pick u_pick (
    .req        (bus.req_i),
    .last_owner (last_owner),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      rdata      <= '0;
      rvalid     <= '0;
    end else begin
      state  <= state_d;
      owner  <= owner_d;
      rvalid <= '0;
      if (state == ACCESS) begin
        last_owner <= owner;
      end
      if (access && !mem_wr_o) begin
        rdata         <= mem_rdata_i;
        rvalid[owner] <= 1'b1;
      end
    end
  end

  // A dropped request in ACCESS is a protocol violation: no memory op, back to IDLE.
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    gnt         = '0;
    access      = 1'b0;
    mem_wr_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state)
      IDLE: begin
        if (|bus.req_i) begin
          state_d = ACCESS;
          owner_d = winner;
        end
      end
      ACCESS: begin
        if (bus.req_i[owner]) begin
          access      = 1'b1;
          gnt[owner]  = 1'b1;
          mem_wr_o    = bus.we_i[owner];
          mem_addr_o  = owner ? bus.addr1_i : bus.addr0_i;
          mem_wdata_o = owner ? bus.wdata1_i : bus.wdata0_i;
        end
        if (!(bus.req_i[owner] && bus.lock_i[owner])) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized checks of dmem_arbiter against a slot-level reference model
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mem_wr;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int n_checks = 0;
  int n_fail = 0;
  bit model_on = 1'b0;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mem_wr_o    (mem_wr),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory behind the arbiter: asynchronous read, synchronous write.
  logic [7:0] mem [256];
  bit mem_ready = 1'b0;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem_ready <= 1'b1;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Reference model: 'slot' is the port whose access slot is the current cycle (-1: none).
  int         slot;
  int         last_port;
  int         rv_port;
  logic [7:0] rv_data;
  logic [7:0] ref_mem [256];
  bit         ref_ready = 1'b0;

  function automatic int choose(input logic [1:0] r, input int last);
    if (r == 2'b11) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      return 1 - last;
`else
      return 0;
`endif
    end
    return r[0] ? 0 : 1;
  endfunction

  function automatic logic [7:0] port_addr(input int p);
    return (p == 1) ? bus.addr1_i : bus.addr0_i;
  endfunction

  function automatic logic [7:0] port_wdata(input int p);
    return (p == 1) ? bus.wdata1_i : bus.wdata0_i;
  endfunction

  function automatic bit served(input int p);
    if (p < 0) return 1'b0;
    return bus.req_i[p];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!ref_ready) begin
      for (int i = 0; i < 256; i++) ref_mem[i] <= 8'(i) ^ 8'h5A;
      ref_ready <= 1'b1;
    end
    if (!rst_n) begin
      slot      <= -1;
      last_port <= 1;
      rv_port   <= -1;
      rv_data   <= 8'h00;
    end else if (slot < 0) begin
      rv_port <= -1;
      slot    <= (bus.req_i != 2'b00) ? choose(bus.req_i, last_port) : -1;
    end else begin
      last_port <= slot;
      slot      <= (bus.req_i[slot] && bus.lock_i[slot]) ? slot : -1;
      rv_port   <= (served(slot) && !bus.we_i[slot]) ? slot : -1;
      if (served(slot) && !bus.we_i[slot]) rv_data <= ref_mem[port_addr(slot)];
      if (served(slot) && bus.we_i[slot]) ref_mem[port_addr(slot)] <= port_wdata(slot);
    end
  end

  function automatic logic [1:0] exp_gnt();
    if (!served(slot)) return 2'b00;
    return (slot == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && model_on) begin
      chk("m_gnt", 32'(bus.gnt_o), 32'(exp_gnt()));
      chk("m_mem_wr", 32'(mem_wr), served(slot) ? 32'(bus.we_i[slot]) : 32'd0);
      chk("m_mem_addr", 32'(mem_addr), served(slot) ? 32'(port_addr(slot)) : 32'd0);
      chk("m_mem_wdata", 32'(mem_wdata), served(slot) ? 32'(port_wdata(slot)) : 32'd0);
      chk("m_rvalid", 32'(bus.rvalid_o), (rv_port < 0) ? 32'd0 : (rv_port == 1 ? 32'd2 : 32'd1));
      chk("m_rdata", 32'(bus.rdata_o), 32'(rv_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic l,
                          input logic [7:0] a, input logic [7:0] d);
    bus.req_i[p]  = r;
    bus.we_i[p]   = w;
    bus.lock_i[p] = l;
    if (p == 0) begin
      bus.addr0_i  = a;
      bus.wdata0_i = d;
    end else begin
      bus.addr1_i  = a;
      bus.wdata1_i = d;
    end
  endtask

  int         order [4];
  int         exp_order [4];
  int         ng;
  int         cyc;
  logic [1:0] g;

  initial begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    set_port(0, 0, 0, 0, 8'h00, 8'h00);
    set_port(1, 0, 0, 0, 8'h00, 8'h00);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt_o), 0);
    chk("rst_rvalid", 32'(bus.rvalid_o), 0);
    chk("rst_rdata", 32'(bus.rdata_o), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_on = 1'b1;

    // port 0 write then read-back of 0x10
    tick(); set_port(0, 1, 1, 0, 8'h10, 8'hA5);
    @(negedge clk); chk("wr_n_gnt", 32'(bus.gnt_o), 0);
    tick();
    @(negedge clk);
    chk("wr_gnt", 32'(bus.gnt_o), 1);
    chk("wr_mem_wr", 32'(mem_wr), 1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h10);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
    tick(); set_port(0, 1, 0, 0, 8'h10, 8'h00);
    @(negedge clk); chk("rd_n_gnt", 32'(bus.gnt_o), 0);
    tick();
    @(negedge clk);
    chk("rd_gnt", 32'(bus.gnt_o), 1);
    chk("rd_mem_wr", 32'(mem_wr), 0);
    tick(); set_port(0, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("rd_rvalid", 32'(bus.rvalid_o), 1);
    chk("rd_rdata", 32'(bus.rdata_o), 32'hA5);

    // asynchronous reset in the middle of a write to 0x20
    tick(); set_port(0, 1, 1, 0, 8'h20, 8'h77);
    @(negedge clk);
    tick();
    @(negedge clk); chk("ar_mem_wr_before", 32'(mem_wr), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_mem_wr", 32'(mem_wr), 0);
    chk("ar_gnt", 32'(bus.gnt_o), 0);
    chk("ar_rvalid", 32'(bus.rvalid_o), 0);
    chk("ar_rdata", 32'(bus.rdata_o), 0);
    chk("ar_mem_addr", 32'(mem_addr), 0);
    chk("ar_mem_wdata", 32'(mem_wdata), 0);
    set_port(0, 0, 0, 0, 8'h00, 8'h00);
    @(posedge clk);
    #3 rst_n = 1'b1;
    chk("ar_mem_kept", 32'(mem[8'h20]), 32'h7A);

    // both ports keep requesting reads: first contest after reset
    tick();
    set_port(0, 1, 0, 0, 8'h01, 8'h00);
    set_port(1, 1, 0, 0, 8'h02, 8'h00);
    ng = 0;
    cyc = 0;
    while (ng < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      g = bus.gnt_o;
      if (g != 2'b00) begin
        order[ng] = g[1] ? 1 : 0;
        ng++;
      end
      tick();
      if (g[0]) bus.addr0_i = bus.addr0_i + 8'd2;
      if (g[1]) bus.addr1_i = bus.addr1_i + 8'd2;
    end
    set_port(0, 0, 0, 0, 8'h00, 8'h00);
    set_port(1, 0, 0, 0, 8'h00, 8'h00);
    chk("arb_grants", 32'(ng), 4);
    for (int i = 0; i < 4; i++) chk("arb_order", 32'(order[i]), 32'(exp_order[i]));

    // port 1 locked burst of reads 0x00..0x02 while port 0 waits
    tick(); tick();
    set_port(1, 1, 0, 1, 8'h00, 8'h00);
    @(negedge clk); chk("lk_n_gnt", 32'(bus.gnt_o), 0);
    tick(); set_port(0, 1, 0, 0, 8'h30, 8'h00);
    @(negedge clk);
    chk("lk_gnt0", 32'(bus.gnt_o), 2);
    chk("lk_addr0", 32'(mem_addr), 0);
    tick(); set_port(1, 1, 0, 1, 8'h01, 8'h00);
    @(negedge clk);
    chk("lk_gnt1", 32'(bus.gnt_o), 2);
    chk("lk_addr1", 32'(mem_addr), 1);
    chk("lk_rdata0", 32'(bus.rdata_o), 32'h5A);
    tick(); set_port(1, 1, 0, 0, 8'h02, 8'h00);
    @(negedge clk);
    chk("lk_gnt2", 32'(bus.gnt_o), 2);
    chk("lk_addr2", 32'(mem_addr), 2);
    tick(); set_port(1, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("lk_release", 32'(bus.gnt_o), 0);
    chk("lk_rdata2", 32'(bus.rdata_o), 32'h58);
    tick();
    @(negedge clk); chk("lk_p0_after", 32'(bus.gnt_o), 1);
    tick(); set_port(0, 0, 0, 0, 8'h00, 8'h00);

    // port 0 abandons its request in the ACCESS cycle
    tick(); set_port(0, 1, 1, 0, 8'h40, 8'h33);
    @(negedge clk);
    tick(); set_port(0, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("vi_gnt", 32'(bus.gnt_o), 0);
    chk("vi_mem_wr", 32'(mem_wr), 0);
    tick(); set_port(1, 1, 1, 0, 8'h41, 8'h99);
    @(negedge clk); chk("vi_idle", 32'(bus.gnt_o), 0);
    tick();
    @(negedge clk);
    chk("vi_recover", 32'(bus.gnt_o), 2);
    chk("vi_addr", 32'(mem_addr), 32'h41);
    tick(); set_port(1, 0, 0, 0, 8'h00, 8'h00);

    // randomized traffic; each requester holds its request until granted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = bus.gnt_o;
      tick();
      for (int p = 0; p < 2; p++) begin
        if (!bus.req_i[p] || g[p]) begin
          if ($urandom_range(0, 99) < 45)
            set_port(p, 1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                     8'($urandom_range(0, 15)), 8'($urandom));
          else
            set_port(p, 0, 0, 0, 8'h00, 8'h00);
        end
      end
    end
    @(negedge clk);
    g = bus.gnt_o;
    tick();
    for (int p = 0; p < 2; p++) if (g[p]) set_port(p, 0, 0, 0, 8'h00, 8'h00);
    for (int c = 0; c < 20 && bus.req_i != 2'b00; c++) begin
      @(negedge clk);
      g = bus.gnt_o;
      tick();
      for (int p = 0; p < 2; p++) if (g[p]) set_port(p, 0, 0, 0, 8'h00, 8'h00);
    end
    chk("drain", 32'(bus.req_i), 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port request/grant arbiter that shares the single-port data memory (2^ADDR_W words × DATA_W bits, asynchronous read, write-enable) between the core load/store unit (port 0) and a secondary master such as a debug or DMA loader (port 1). It sequences every access through a two-state FSM and drives the memory's write enable, address and write data. It also registers the read result and returns it to the winning requester with a valid pulse.

## Interface
Parameters:
- ADDR_W, 8, memory address width; equals the memory's address-length parameter.
- DATA_W, 8, memory word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i[1:0]  in  2  per-port access request.
- we_i[1:0]  in  2  per-port write (1) or read (0).
- lock_i[1:0]  in  2  per-port hold-ownership request for back-to-back accesses.
- addr0_i / addr1_i  in  ADDR_W  per-port address.
- wdata0_i / wdata1_i  in  DATA_W  per-port write data.
- gnt_o[1:0]  out  2  one-cycle pulse; the access is performed in this cycle.
- rvalid_o[1:0]  out  2  read data valid, one cycle.
- rdata_o  out  DATA_W  registered read data, shared by both ports.
- mem_wr_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory asynchronous read data.

## Operation
- Registers: state {IDLE, ACCESS}, owner (1 bit), last_owner (1 bit), rdata, rvalid.
- IDLE behaviour:
  - If no request is pending, stay in IDLE.
  - If any req_i is high, latch the winner into owner and go to ACCESS.
- ACCESS behaviour:
  - If req_i[owner] is high: mem_addr_o/mem_wdata_o = owner's addr/wdata, mem_wr_o = we_i[owner], and gnt_o[owner] = 1.
  - On a read, capture mem_rdata_i into rdata at the cycle end.
  - last_owner <= owner.
- Leaving ACCESS:
  - Stay in ACCESS with the same owner if req_i[owner] && lock_i[owner]; lock overrides arbitration.
  - Otherwise return to IDLE.
- Protocol rules:
  - A requester holds req, we, addr, wdata and lock stable from assertion until gnt.
  - If req_i[owner] is low in ACCESS (protocol violation), drive no memory op and no gnt, and return to IDLE.
- Memory outputs outside ACCESS: mem_wr_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
- mem_wr_o is never asserted outside a granted cycle.
- Simultaneous requests are resolved per Configuration. A write and a read to the same address from different ports are serialised in grant order.

## Timing
- Reset values: state = IDLE, owner = 0, last_owner = 1, gnt_o = 0, rvalid_o = 0, rdata_o = 0, mem_* = 0.
- Reset is asynchronous: asserting it mid-ACCESS drops mem_wr_o immediately and abandons the access, with no gnt or rvalid.
- Unlocked access:
  - Cycle N: req sampled.
  - Cycle N+1: gnt pulse and memory op.
  - Cycle N+2: rvalid_o[owner] = 1 with rdata_o, reads only.
  - Throughput is one access per 2 cycles.
- Locked burst: one access per cycle. gnt stays high on consecutive cycles and rvalid follows each read gnt by one cycle.
- Writes produce no rvalid.
- rdata_o holds its last value when rvalid_o is 0.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, the winner is ~last_owner. Port 0 wins the first contest after reset.
- Undefined: fixed priority, port 0 always wins; last_owner is still maintained but unused.
- Lock behaviour is identical in both builds.

## Structure
- Package dmem_arb_pkg:
  - state enum typedef (IDLE, ACCESS).
  - port index typedef.
  - NUM_PORTS = 2 constant.
- Sub-module dmem_arb_pick: combinational winner selection from req_i and last_owner, with the macro-dependent policy isolated there.

## Test plan
- Port 0 write addr 0x10 data 0xA5, then port 0 read 0x10 -> gnt_o[0] at N+1 with mem_wr_o = 1; the read returns rvalid_o[0] with rdata_o = 0xA5 two cycles after req.
- Both ports request reads at the same cycle, repeated 4 times:
  - With the RR macro: grants alternate 0,1,0,1.
  - Without it: port 0 always wins while it keeps requesting.
- Port 1 asserts lock with 3 back-to-back reads of 0x00–0x02 while port 0 requests -> gnt_o[1] high for 3 consecutive cycles; port 0 is granted only after lock drops.
- Assert rst_n low during an ACCESS write to 0x20 -> mem_wr_o falls asynchronously, no gnt or rvalid, all outputs at reset values.
- Port 0 drops req in the ACCESS cycle -> no gnt, mem_wr_o stays 0, FSM returns to IDLE.
